// File: rtl/replica_lane_node.sv
// replica_lane_node
// Holds LANES consecutive replicas' total tour distances. Lane i is global
// replica ID*LANES+i. Applies per-lane delta updates from the opt engines,
// runs the replica exchange round (internal pairs and the boundary pair with
// the following node), and provides the serial distance shift chain.
//
// Ports:
//   clk, reset (async, active low)
//   dis_shift, dis_shift_in, dis_shift_out     serial distance chain
//   delta_valid, delta_data, delta_accept      per-lane delta updates
//   delta_drop                                 a valid delta was discarded
//   ex_start, ex_parity, force_ex              exchange round control
//   prev_dis, folw_dis, prev_exchange          neighbour node taps
//   out_first_dis, out_last_dis, out_ex_folw   taps to neighbour nodes
//   out_exchange, ex_done                      round result / completion
//   cnt_clear, ex_count                        per-lane swap counters
module replica_lane_node #(
  parameter int ID        = 0,
  parameter int LANES     = 2,
  parameter int DIS_W     = 32,
  parameter int DELTA_W   = 24,
  parameter int LAST_NODE = 0,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dis_shift,
  input  logic [DIS_W-1:0]         dis_shift_in,
  output logic [DIS_W-1:0]         dis_shift_out,
  input  logic [LANES-1:0]         delta_valid,
  input  logic [LANES*DELTA_W-1:0] delta_data,
  input  logic [LANES-1:0]         delta_accept,
  output logic                     delta_drop,
  input  logic                     ex_start,
  input  logic                     ex_parity,
  input  logic [LANES-1:0]         force_ex,
  input  logic [DIS_W-1:0]         prev_dis,
  input  logic [DIS_W-1:0]         folw_dis,
  output logic [DIS_W-1:0]         out_first_dis,
  output logic [DIS_W-1:0]         out_last_dis,
  input  logic                     prev_exchange,
  output logic                     out_ex_folw,
  output logic [LANES-1:0]         out_exchange,
  output logic                     ex_done,
  input  logic                     cnt_clear,
  output logic [LANES*CNT_W-1:0]   ex_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_COMPARE, ST_SWAP} state_t;

  localparam int   BASE     = ID * LANES;
  // Replica BASE-1 (last lane of the previous node) has the parity of BASE+1.
  localparam logic PREV_PAR = ((BASE + 1) % 2) == 1;
  localparam logic HAS_PREV = (ID > 0);

  state_t state_reg, state_next;

  logic [DIS_W-1:0] dis_reg [LANES];
  logic [LANES-1:0] exch_reg;        // bit i: pair with lower lane i swaps; top bit is the boundary pair
  logic [LANES-1:0] exch_next;
  logic             parity_reg;
  logic [DIS_W-1:0] folw_snap_reg;
  logic [DIS_W-1:0] prev_snap_reg;

  logic [LANES-1:0]            upd_en;
  logic [LANES-1:0][DIS_W-1:0] upd_val;
  logic [LANES-1:0]            swap_en;
  logic [LANES-1:0][DIS_W-1:0] swap_val;

  logic in_idle;
  assign in_idle = (state_reg == ST_IDLE);

  assign dis_shift_out = dis_reg[LANES-1];
  assign out_first_dis = dis_reg[0];
  assign out_last_dis  = dis_reg[LANES-1];
  assign out_ex_folw   = exch_reg[LANES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (ex_start) state_next = ST_COMPARE;
      ST_COMPARE: state_next = ST_SWAP;
      ST_SWAP:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic LANE_PAR = ((BASE + gi) % 2) == 1;

      logic [DELTA_W-1:0] delta;
      logic [DIS_W+1:0]   sum;
      logic               up_en, down_en;
      logic [DIS_W-1:0]   up_val, down_val;
      logic [CNT_W-1:0]   cnt_reg;

      // Two extra bits: top bit flags underflow below 0, next flags overflow.
      assign delta = delta_data[gi*DELTA_W +: DELTA_W];
      assign sum   = {2'b00, dis_reg[gi]} + {{(DIS_W+2-DELTA_W){delta[DELTA_W-1]}}, delta};
      // Non-positive deltas always apply; positive ones need the Metropolis accept.
      assign upd_en[gi]  = delta_valid[gi] && (delta[DELTA_W-1] || (delta == '0) || delta_accept[gi]);
      assign upd_val[gi] = sum[DIS_W+1] ? '0 : (sum[DIS_W] ? '1 : sum[DIS_W-1:0]);

      if (gi < LANES - 1) begin : g_inner
        assign exch_next[gi] = (LANE_PAR == parity_reg) &&
                               ((dis_reg[gi+1] < dis_reg[gi]) || force_ex[gi]);
        assign up_val = dis_reg[gi+1];
      end else if (LAST_NODE == 0) begin : g_bnd
        assign exch_next[gi] = (LANE_PAR == parity_reg) &&
                               ((folw_dis < dis_reg[gi]) || force_ex[gi]);
        assign up_val = folw_snap_reg;
      end else begin : g_none
        assign exch_next[gi] = 1'b0;
        assign up_val        = folw_snap_reg;
      end
      assign up_en = exch_reg[gi];

      if (gi > 0) begin : g_down
        assign down_en  = exch_reg[gi-1];
        assign down_val = dis_reg[gi-1];
      end else begin : g_prev
        // The previous node's decision only counts when its lane was an eligible lower lane.
        assign down_en  = prev_exchange && HAS_PREV && (PREV_PAR == parity_reg);
        assign down_val = prev_snap_reg;
      end

      assign swap_en[gi]  = up_en || down_en;
      assign swap_val[gi] = up_en ? up_val : down_val;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          cnt_reg <= '0;
        else if (cnt_clear)
          cnt_reg <= '0;
        else if ((state_reg == ST_SWAP) && swap_en[gi] && (cnt_reg != {CNT_W{1'b1}}))
          cnt_reg <= cnt_reg + 1'b1;
      end
      assign ex_count[gi*CNT_W +: CNT_W] = cnt_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LANES; i++) dis_reg[i] <= '0;
    end else if (in_idle && dis_shift) begin
      dis_reg[0] <= dis_shift_in;
      for (int i = 1; i < LANES; i++) dis_reg[i] <= dis_reg[i-1];
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (in_idle && !ex_start && upd_en[i])
          dis_reg[i] <= upd_val[i];
        else if ((state_reg == ST_SWAP) && swap_en[i])
          dis_reg[i] <= swap_val[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exch_reg      <= '0;
      parity_reg    <= 1'b0;
      folw_snap_reg <= '0;
      prev_snap_reg <= '0;
      out_exchange  <= '0;
      ex_done       <= 1'b0;
      delta_drop    <= 1'b0;
    end else begin
      ex_done    <= (state_reg == ST_SWAP);
      delta_drop <= (|delta_valid) && (!in_idle || ex_start || dis_shift);
      if (in_idle && ex_start) begin
        exch_reg   <= '0;
        parity_reg <= ex_parity;
      end
      if (state_reg == ST_COMPARE) begin
        exch_reg      <= exch_next;
        folw_snap_reg <= folw_dis;
        prev_snap_reg <= prev_dis;
      end
      if (state_reg == ST_SWAP)
        out_exchange <= swap_en;
    end
  end

endmodule

// File: tb/tb_replica_lane_node.sv
// Directed bench for replica_lane_node: two chained nodes (ID 0 and ID 1,
// the latter the last node) plus a standalone node with narrow counters
// used to reach counter saturation quickly.
module tb_replica_lane_node;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dis_shift = 1'b0;
  logic        ex_start = 1'b0;
  logic        ex_parity = 1'b0;
  logic        cnt_clear = 1'b0;

  logic [31:0] shift_in0 = '0;
  logic [31:0] so0, so1, so2;
  logic [1:0]  d0_valid = '0, d0_acc = '0;
  logic [47:0] d0_data = '0;
  logic [1:0]  d_zero2 = '0;
  logic [47:0] d_zero48 = '0;
  logic [31:0] zero32 = '0;
  logic        zero1 = 1'b0;
  logic [1:0]  force0 = '0, force1 = '0, force2 = '0;
  logic        prev_ex0 = 1'b0;
  logic [31:0] folw_dis1 = '0;

  logic        drop0, drop1, drop2;
  logic [31:0] first0, last0, first1, last1, first2, last2;
  logic        folw0, folw1, folw2;
  logic [1:0]  exch0, exch1, exch2;
  logic        done0, done1, done2;
  logic [31:0] cnt0, cnt1;
  logic [7:0]  cnt2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  replica_lane_node #(.ID(0), .LANES(2), .DIS_W(32), .DELTA_W(24), .LAST_NODE(0)) u0 (
    .clk(clk), .reset(reset), .dis_shift(dis_shift), .dis_shift_in(shift_in0),
    .dis_shift_out(so0), .delta_valid(d0_valid), .delta_data(d0_data),
    .delta_accept(d0_acc), .delta_drop(drop0), .ex_start(ex_start),
    .ex_parity(ex_parity), .force_ex(force0), .prev_dis(zero32), .folw_dis(first1),
    .out_first_dis(first0), .out_last_dis(last0), .prev_exchange(prev_ex0),
    .out_ex_folw(folw0), .out_exchange(exch0), .ex_done(done0),
    .cnt_clear(cnt_clear), .ex_count(cnt0));

  replica_lane_node #(.ID(1), .LANES(2), .DIS_W(32), .DELTA_W(24), .LAST_NODE(1)) u1 (
    .clk(clk), .reset(reset), .dis_shift(dis_shift), .dis_shift_in(so0),
    .dis_shift_out(so1), .delta_valid(d_zero2), .delta_data(d_zero48),
    .delta_accept(d_zero2), .delta_drop(drop1), .ex_start(ex_start),
    .ex_parity(ex_parity), .force_ex(force1), .prev_dis(last0), .folw_dis(folw_dis1),
    .out_first_dis(first1), .out_last_dis(last1), .prev_exchange(folw0),
    .out_ex_folw(folw1), .out_exchange(exch1), .ex_done(done1),
    .cnt_clear(cnt_clear), .ex_count(cnt1));

  replica_lane_node #(.ID(0), .LANES(2), .DIS_W(32), .DELTA_W(24), .LAST_NODE(1), .CNT_W(4)) u2 (
    .clk(clk), .reset(reset), .dis_shift(zero1), .dis_shift_in(zero32),
    .dis_shift_out(so2), .delta_valid(d_zero2), .delta_data(d_zero48),
    .delta_accept(d_zero2), .delta_drop(drop2), .ex_start(ex_start),
    .ex_parity(ex_parity), .force_ex(force2), .prev_dis(zero32), .folw_dis(zero32),
    .out_first_dis(first2), .out_last_dis(last2), .prev_exchange(zero1),
    .out_ex_folw(folw2), .out_exchange(exch2), .ex_done(done2),
    .cnt_clear(cnt_clear), .ex_count(cnt2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic shift_val(input logic [31:0] v);
    shift_in0 = v;
    dis_shift = 1'b1;
    tick();
    dis_shift = 1'b0;
  endtask

  task automatic delta0(input int lane, input int val, input logic acc);
    logic [23:0] d;
    d = val[23:0];
    d0_data = '0;
    d0_data[lane*24 +: 24] = d;
    d0_valid = '0;
    d0_valid[lane] = 1'b1;
    d0_acc = '0;
    d0_acc[lane] = acc;
    tick();
    d0_valid = '0;
    d0_acc = '0;
  endtask

  task automatic start_round();
    ex_start = 1'b1;
    tick();
    ex_start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (first0 !== 32'd0) begin n_err++; $display("FAIL reset_lane0: got %0d want 0", first0); end
    n_cmp++; if (last0 !== 32'd0) begin n_err++; $display("FAIL reset_lane1: got %0d want 0", last0); end
    n_cmp++; if ({folw0, exch0, done0, drop0} !== 5'b0) begin n_err++; $display("FAIL reset_ctrl: got %b want 00000", {folw0, exch0, done0, drop0}); end
    n_cmp++; if (cnt0 !== 32'd0) begin n_err++; $display("FAIL reset_cnt: got %h want 0", cnt0); end
    $display("test_reset done");
  endtask

  task automatic test_shift();
    shift_val(32'd100);
    d0_valid = 2'b01; d0_acc = 2'b01; d0_data = 48'd5;
    shift_val(32'd200);
    d0_valid = '0; d0_acc = '0;
    n_cmp++; if (first0 !== 32'd200) begin n_err++; $display("FAIL shift_lane0: got %0d want 200", first0); end
    n_cmp++; if (last0 !== 32'd100) begin n_err++; $display("FAIL shift_lane1: got %0d want 100", last0); end
    n_cmp++; if (so0 !== 32'd100) begin n_err++; $display("FAIL shift_out: got %0d want 100", so0); end
    n_cmp++; if (drop0 !== 1'b1) begin n_err++; $display("FAIL shift_drop: got %b want 1", drop0); end
    tick();
    n_cmp++; if (drop0 !== 1'b0) begin n_err++; $display("FAIL shift_drop_clear: got %b want 0", drop0); end
    $display("test_shift done");
  endtask

  task automatic test_delta();
    shift_val(32'd100);                 // lane0=100, lane1=200
    delta0(0, -30, 1'b0);
    n_cmp++; if (first0 !== 32'd70) begin n_err++; $display("FAIL delta_neg: got %0d want 70", first0); end
    n_cmp++; if (drop0 !== 1'b0) begin n_err++; $display("FAIL delta_nodrop: got %b want 0", drop0); end
    delta0(0, 50, 1'b0);
    n_cmp++; if (first0 !== 32'd70) begin n_err++; $display("FAIL delta_reject: got %0d want 70", first0); end
    delta0(0, 50, 1'b1);
    n_cmp++; if (first0 !== 32'd120) begin n_err++; $display("FAIL delta_accept: got %0d want 120", first0); end
    shift_val(32'd10);                  // lane0=10, lane1=120
    delta0(0, -50, 1'b0);
    n_cmp++; if (first0 !== 32'd0) begin n_err++; $display("FAIL delta_floor: got %0d want 0", first0); end
    shift_val(32'hFFFF_FFF0);           // lane0=FFFFFFF0, lane1=0
    delta0(0, 256, 1'b1);
    n_cmp++; if (first0 !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL delta_ceil: got %h want ffffffff", first0); end
    shift_val(32'd10);                  // lane0=10, lane1=FFFFFFFF
    delta0(1, -3, 1'b0);
    n_cmp++; if (last0 !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL delta_lane1: got %h want fffffffc", last0); end
    $display("test_delta done");
  endtask

  task automatic test_internal();
    do_reset();
    ex_parity = 1'b0;
    shift_val(32'd200);
    shift_val(32'd300);                 // lane0=300, lane1=200
    start_round();                      // COMPARE
    tick();                             // SWAP
    n_cmp++; if ({done0, first0} !== {1'b0, 32'd300}) begin n_err++; $display("FAIL int_t2: got done=%b lane0=%0d want done=0 lane0=300", done0, first0); end
    tick();                             // T+3
    n_cmp++; if (done0 !== 1'b1) begin n_err++; $display("FAIL int_done: got %b want 1", done0); end
    n_cmp++; if ({first0, last0} !== {32'd200, 32'd300}) begin n_err++; $display("FAIL int_swap: got %0d,%0d want 200,300", first0, last0); end
    n_cmp++; if (exch0 !== 2'b11) begin n_err++; $display("FAIL int_exch: got %b want 11", exch0); end
    n_cmp++; if (cnt0 !== {16'd1, 16'd1}) begin n_err++; $display("FAIL int_cnt: got %h want 00010001", cnt0); end
    tick();
    n_cmp++; if ({done0, exch0} !== 3'b011) begin n_err++; $display("FAIL int_after: got done=%b exch=%b want done=0 exch=11", done0, exch0); end
    start_round();
    tick();
    tick();
    n_cmp++; if ({first0, last0} !== {32'd200, 32'd300}) begin n_err++; $display("FAIL noswap_lanes: got %0d,%0d want 200,300", first0, last0); end
    n_cmp++; if (exch0 !== 2'b00) begin n_err++; $display("FAIL noswap_exch: got %b want 00", exch0); end
    n_cmp++; if (cnt0 !== {16'd1, 16'd1}) begin n_err++; $display("FAIL noswap_cnt: got %h want 00010001", cnt0); end
    $display("test_internal done");
  endtask

  task automatic test_boundary();
    do_reset();
    ex_parity = 1'b1;
    folw_dis1 = 32'd0;
    shift_val(32'd900);
    shift_val(32'd400);
    shift_val(32'd500);
    shift_val(32'd50);                  // u0 {50,500}, u1 {400,900}
    start_round();
    tick();                             // SWAP cycle
    n_cmp++; if (folw0 !== 1'b1) begin n_err++; $display("FAIL bnd_folw0: got %b want 1", folw0); end
    n_cmp++; if (folw1 !== 1'b0) begin n_err++; $display("FAIL last_folw1: got %b want 0", folw1); end
    tick();
    n_cmp++; if ({last0, first1} !== {32'd400, 32'd500}) begin n_err++; $display("FAIL bnd_swap: got %0d,%0d want 400,500", last0, first1); end
    n_cmp++; if ({first0, last1} !== {32'd50, 32'd900}) begin n_err++; $display("FAIL bnd_others: got %0d,%0d want 50,900", first0, last1); end
    n_cmp++; if ({exch0, exch1} !== 4'b1001) begin n_err++; $display("FAIL bnd_exch: got %b want 1001", {exch0, exch1}); end
    n_cmp++; if (done1 !== 1'b1) begin n_err++; $display("FAIL bnd_done1: got %b want 1", done1); end
    start_round();
    n_cmp++; if (folw0 !== 1'b0) begin n_err++; $display("FAIL bnd_folw_clear: got %b want 0", folw0); end
    tick();
    tick();
    $display("test_boundary done");
  endtask

  task automatic test_busy_drop();
    do_reset();
    ex_parity = 1'b0;
    shift_val(32'd7);
    shift_val(32'd5);                   // lane0=5, lane1=7: no swap
    ex_start = 1'b1;
    d0_valid = 2'b01; d0_data = {24'd0, 24'hFFFFFF};
    tick();                             // COMPARE
    ex_start = 1'b0;
    n_cmp++; if (drop0 !== 1'b1) begin n_err++; $display("FAIL drop_start: got %b want 1", drop0); end
    tick();                             // SWAP (delta seen in COMPARE)
    n_cmp++; if (drop0 !== 1'b1) begin n_err++; $display("FAIL drop_busy: got %b want 1", drop0); end
    d0_valid = '0;
    tick();
    n_cmp++; if (first0 !== 32'd5) begin n_err++; $display("FAIL drop_lane0: got %0d want 5", first0); end
    $display("test_busy_drop done");
  endtask

  task automatic test_reset_mid();
    int bad_done;
    do_reset();
    ex_parity = 1'b0;
    shift_val(32'd200);
    shift_val(32'd300);                 // {300,200}
    start_round();                      // COMPARE
    #2 reset = 1'b0;
    #1;
    n_cmp++; if ({first0, last0} !== 64'd0) begin n_err++; $display("FAIL mid_lanes: got %0d,%0d want 0,0", first0, last0); end
    n_cmp++; if (cnt0 !== 32'd0) begin n_err++; $display("FAIL mid_cnt: got %h want 0", cnt0); end
    tick();
    reset = 1'b1;
    bad_done = 0;
    for (int k = 0; k < 4; k++) begin
      if (done0 !== 1'b0) bad_done++;
      tick();
    end
    n_cmp++; if (bad_done != 0) begin n_err++; $display("FAIL mid_done: got %0d pulses want 0", bad_done); end
    n_cmp++; if ({first0, last0, cnt0} !== 96'd0) begin n_err++; $display("FAIL mid_idle: got %0d,%0d cnt=%h want 0,0,0", first0, last0, cnt0); end
    $display("test_reset_mid done");
  endtask

  task automatic test_saturate();
    do_reset();
    ex_parity = 1'b0;
    force2 = 2'b01;
    for (int r = 0; r < 20; r++) begin
      start_round();
      tick();
      tick();
      if (r == 13) begin
        n_cmp++; if (cnt2 !== {4'd14, 4'd14}) begin n_err++; $display("FAIL sat_14: got %h want ee", cnt2); end
      end
    end
    n_cmp++; if (cnt2 !== {4'd15, 4'd15}) begin n_err++; $display("FAIL sat_15: got %h want ff", cnt2); end
    start_round();                      // COMPARE
    tick();                             // SWAP
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    n_cmp++; if (cnt2 !== 8'h00) begin n_err++; $display("FAIL sat_clear: got %h want 00", cnt2); end
    n_cmp++; if (done2 !== 1'b1) begin n_err++; $display("FAIL sat_done: got %b want 1", done2); end
    force2 = 2'b00;
    $display("test_saturate done");
  endtask

  initial begin
    test_reset();
    test_shift();
    test_delta();
    test_internal();
    test_boundary();
    test_busy_drop();
    test_reset_mid();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/replica_lane_node.md
# replica_lane_node

Parametrised replica node holding `LANES` consecutive replicas' total tour distances, generalising the fixed two-lane (or-opt / 2-opt) node to N lanes. Applies per-lane delta-distance updates from the opt engines and runs the replica exchange round: neighbouring replica pairs are compared, both inside the node and across node boundaries, and distances are swapped. It also provides the serial distance shift chain for host read/write. Instances are chained node to node by their prev/folw ports.

## Interface
- `ID`, 0, node index; lane i is global replica `ID*LANES+i`
- `LANES`, 2, replicas per node (≥2)
- `DIS_W`, 32, total-distance width (unsigned)
- `DELTA_W`, 24, delta-distance width (two's complement)
- `LAST_NODE`, 0, 1 = no following node; the boundary pair is never exchanged
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low reset
- `dis_shift`  in  1  shift distance chain one lane
- `dis_shift_in`  in  DIS_W  enters lane 0
- `dis_shift_out`  out  DIS_W  lane LANES-1 value (combinational from register)
- `delta_valid`  in  LANES  per-lane delta present
- `delta_data`  in  LANES*DELTA_W  lane i at bits [i*DELTA_W +: DELTA_W]
- `delta_accept`  in  LANES  Metropolis accept for positive deltas
- `delta_drop`  out  1  pulse: a valid delta was discarded
- `ex_start`  in  1  start exchange round (ignored unless IDLE)
- `ex_parity`  in  1  pair (r,r+1) eligible iff r%2 == ex_parity
- `force_ex`  in  LANES  force exchange of the pair whose lower lane is i
- `prev_dis`  in  DIS_W  previous node's lane LANES-1
- `folw_dis`  in  DIS_W  following node's lane 0
- `out_first_dis`, `out_last_dis`  out  DIS_W  lane 0 / lane LANES-1 registers
- `prev_exchange`  in  1  previous node's `out_ex_folw`
- `out_ex_folw`  out  1  boundary pair with following node exchanges
- `out_exchange`  out  LANES  lane swapped in the last round (held until next round)
- `ex_done`  out  1  one-cycle pulse at round end
- `cnt_clear`  in  1  clear exchange counters
- `ex_count`  out  LANES*16  per-lane saturating swap count

## Operation
- FSM: IDLE → COMPARE (ex_start) → SWAP → IDLE. COMPARE and SWAP last one cycle each. Reset (any state) → IDLE, all registers/outputs 0.
- IDLE priority: `dis_shift` > delta update. A shift moves lane i→i+1 and loads `dis_shift_in` into lane 0. Any `delta_valid` in the same cycle is dropped (`delta_drop`=1 next cycle).
- Delta update (IDLE, no shift): applied when `delta_valid[i]` and (delta ≤ 0 or `delta_accept[i]`). new = dis + sign-extended delta, clamped to [0, 2^DIS_W−1].
- `delta_valid` while COMPARE/SWAP, or while `ex_start` is sampled in IDLE, is dropped with `delta_drop`. `dis_shift` outside IDLE is ignored.
- COMPARE: snapshot all lanes, `prev_dis`, `folw_dis`, `force_ex`. For each eligible lower lane i<LANES−1: exch = lane[i+1] < lane[i] or force_ex[i]. Boundary (i=LANES−1, if eligible and LAST_NODE=0): exch = folw_dis < lane[LANES−1] or force_ex[LANES−1]. Register the result into `out_ex_folw`.
- SWAP: swap decided internal pairs. The boundary lower lane takes the `folw_dis` snapshot if `out_ex_folw`. Lane 0 takes the `prev_dis` snapshot if `prev_exchange`=1 and global replica ID*LANES−1 is an eligible lower lane. Otherwise `prev_exchange` is ignored. Set `out_exchange`, increment counters (saturate at 65535), pulse `ex_done` on the SWAP→IDLE edge.
- `cnt_clear` has priority over increment in the same cycle.
- Pairs are disjoint per parity, so there are no per-lane conflicts.

## Timing
- All outputs registered except `dis_shift_out`, `out_first_dis`, `out_last_dis`, which are direct register taps.
- Delta/shift latency: 1 cycle.
- Exchange round: ex_start at cycle T. COMPARE at T+1, `out_ex_folw` valid T+2, SWAP writes at T+2 edge, `ex_done` high in cycle T+3, `out_exchange` valid from T+3.
- All nodes receive `ex_start` in the same cycle. `prev_exchange` is sampled only during SWAP.
- `ex_start` while busy: ignored.
- `out_ex_folw` is cleared on the next ex_start.

## Test plan
- Shift load: LANES=2, shift in 100 then 200 → lane0=200, lane1=100, `dis_shift_out`=100. A delta in the same cycle as the shift sets `delta_drop`=1.
- Delta rules: lane0=100. Delta −30 → 70. Delta +50 with accept=0 → 70. Delta +50 with accept=1 → 120. lane0=10 with delta −50 → 0. Lane at 0xFFFFFFF0 with +0x100 accepted → 0xFFFFFFFF.
- Internal exchange: ID=0, parity 0, lanes {300,200} → {200,300}, `out_exchange`=2'b11, `ex_done` at T+3, counters 1. With lanes {200,300} and force_ex=0 → no swap.
- Boundary: two nodes, ID=0/1, parity 1. Node0 lane1=500, node1 lane0=400 → node0 `out_ex_folw`=1, node0 lane1=400, node1 lane0=500 in the same cycle.
- LAST_NODE=1, parity 1, folw_dis=0 → no boundary exchange, `out_ex_folw`=0.
- Reset low during COMPARE → IDLE, counters 0, no `ex_done`. A delta during the busy round is dropped with `delta_drop`. 70000 forced swaps → counter 65535.
